// File: rtl/dff_pipe_pkg.sv
// -----------------------------------------------------------------------------
// dff_pipe_pkg
//
// Shared helpers for the _dff_pipe_r register pipeline.
//   clog2()        : ceiling log2, used to size the occupancy counter
//                    (CNT_W = clog2(DEPTH + 1)).
//   depth_legal()  : elaboration-time legality check for the DEPTH parameter.
//   MIN_DEPTH      : smallest legal stage count.
// -----------------------------------------------------------------------------
package dff_pipe_pkg;

  localparam int MIN_DEPTH = 1;

  // Ceiling log2 for elaboration-time sizing. clog2(1) = 0, clog2(5) = 3.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // A pipeline without stages has no output register to drive q from.
  function automatic bit depth_legal(input int depth);
    return depth >= MIN_DEPTH;
  endfunction

endpackage

// File: rtl/_dff_pipe_r_stage.sv
// -----------------------------------------------------------------------------
// _dff_pipe_stage
//
// One stage of the _dff_pipe_r pipeline: a WIDTH-bit data register plus its
// valid bit, both cleared by the asynchronous active-low reset.
//
// Ports
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset (clears data and valid)
//   load       in   take valid_in/data_in at the next edge
//   flush      in   clear the valid bit at the next edge; data is held
//   valid_in   in   valid bit from the previous stage (or the input transfer)
//   data_in    in   data from the previous stage (or the d port)
//   valid_out  out  registered valid bit
//   data_out   out  registered data
// -----------------------------------------------------------------------------
module _dff_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             flush,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             valid_out,
  output logic [WIDTH-1:0] data_out
);

  logic             valid_d;
  logic             valid_q;
  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      // Flush only invalidates; the data register keeps its old contents.
      valid_d = 1'b0;
    end else if (load) begin
      // Data follows the predecessor even when the incoming valid is 0,
      // so the data path needs no extra enable qualification.
      valid_d = valid_in;
      data_d  = data_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;

endmodule

// File: rtl/_dff_pipe_r.sv
// -----------------------------------------------------------------------------
// _dff_pipe_r
//
// WIDTH x DEPTH register pipeline with valid/ready flow control, bubble
// collapsing and synchronous flush. Used as a delay/retiming element that
// tolerates downstream back-pressure without losing or duplicating words.
//
// Handshake: a word moves across an interface on a rising edge exactly when
// valid and ready are both 1 in the cycle before that edge. in_valid/d must be
// held by the producer until in_ready is seen; out_valid/q are held by this
// block until out_ready is seen. in_ready depends combinationally on
// out_ready (it ripples back through the stage chain) and is forced low
// while flush is high.
//
// Parameters
//   WIDTH  data bits per stage (>= 1)
//   DEPTH  number of register stages (>= 1)
//   CNT_W  derived width of count, clog2(DEPTH + 1)
//
// Ports
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   flush      in   synchronous clear of every valid bit; no accept that cycle
//   in_valid   in   upstream word present on d
//   in_ready   out  block accepts d this cycle
//   d          in   input data
//   out_valid  out  q holds a valid word
//   out_ready  in   downstream accepts q this cycle
//   q          out  output data (last stage)
//   count      out  number of valid stages (registered)
//
// Build option
//   DFF_PIPE_COUNT_EN  when defined, the occupancy counter is built; when
//                      undefined, count is tied to zero.
// -----------------------------------------------------------------------------
module _dff_pipe_r
  import dff_pipe_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CNT_W = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [CNT_W-1:0] count
);

  localparam bit DEPTH_OK = depth_legal(DEPTH);

  if (!DEPTH_OK) begin : g_depth_check
    $error("_dff_pipe_r: DEPTH must be at least 1");
  end

  logic             stage_valid [DEPTH];
  logic [WIDTH-1:0] stage_data  [DEPTH];
  logic [DEPTH-1:0] adv;
  logic             push;

  // adv[i] = ~v[i] | adv[i+1], with adv[DEPTH-1] = ~v[DEPTH-1] | out_ready.
  // Unrolled as "some stage at or after i is empty, or the output drains",
  // tracked with a running AND of the valid bits from the output end.
  always_comb begin
    logic full_tail;
    full_tail = 1'b1;
    adv       = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      full_tail = full_tail & stage_valid[i];
      adv[i]    = ~full_tail | out_ready;
    end
  end

  assign in_ready  = adv[0] & ~flush;
  assign push      = in_valid & in_ready;
  assign out_valid = stage_valid[DEPTH-1];
  assign q         = stage_data[DEPTH-1];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             valid_src;
    logic [WIDTH-1:0] data_src;

    if (i == 0) begin : g_head
      // The head valid is the accepted transfer, not raw in_valid.
      assign valid_src = push;
      assign data_src  = d;
    end else begin : g_body
      assign valid_src = stage_valid[i-1];
      assign data_src  = stage_data[i-1];
    end

    _dff_pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (adv[i]),
      .flush     (flush),
      .valid_in  (valid_src),
      .data_in   (data_src),
      .valid_out (stage_valid[i]),
      .data_out  (stage_data[i])
    );
  end

`ifdef DFF_PIPE_COUNT_EN
  logic             pop;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;

  assign pop = out_valid & out_ready;

  // Push and pop on the same edge cancel; flush wins over both and matches
  // the valid bits all clearing on that edge.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
`else
  assign count = '0;
`endif

endmodule

// File: tb/tb__dff_pipe_r.sv
module tb__dff_pipe_r;
  import dff_pipe_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = clog2(DEPTH + 1);

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             reset_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] d;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] q;
  logic [CNT_W-1:0] count;

  always #5 clk = ~clk;

  _dff_pipe_r #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .count     (count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model / scoreboard ----------------
  // Words in flight, oldest first, with the stage index each word sits in.
  logic [WIDTH-1:0] exp_q[$];
  int               pos_q[$];

  function automatic bit m_out_valid();
    return (exp_q.size() > 0) && (pos_q[0] == DEPTH - 1);
  endfunction

  // Full means every stage holds a word; then only a draining output frees room.
  function automatic bit m_in_ready();
    return ((exp_q.size() < DEPTH) || out_ready) && !flush;
  endfunction

  function automatic int m_count();
`ifdef DFF_PIPE_COUNT_EN
    return exp_q.size();
`else
    return 0;
`endif
  endfunction

  function automatic int m_peak(input int n);
`ifdef DFF_PIPE_COUNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  // Advance the model across one rising edge using the inputs currently driven.
  // A word moves forward unless every slot ahead of it is occupied by older
  // words and the output is stalled.
  task automatic tick();
    bit push, pop;
    push = in_valid && m_in_ready();
    pop  = m_out_valid() && out_ready;
    @(posedge clk);
    if (flush) begin
      exp_q.delete();
      pos_q.delete();
    end else begin
      if (pop) begin
        void'(exp_q.pop_front());
        void'(pos_q.pop_front());
      end
      foreach (pos_q[k]) begin
        if (out_ready || (pos_q[k] < DEPTH - 1 - k)) pos_q[k] = pos_q[k] + 1;
      end
      if (push) begin
        exp_q.push_back(d);
        pos_q.push_back(0);
      end
    end
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; d = '0;
    exp_q.delete(); pos_q.delete();
    #2;
    n_tests += 4;
    if (q !== '0) begin n_fail++; $display("FAIL reset_q got %h want 00", q); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    if (count !== '0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    flush = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_flush_in_ready got %b want 0", in_ready); end
    flush = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_latency();
    logic [WIDTH-1:0] words[3] = '{8'h11, 8'h22, 8'h33};
    logic [WIDTH-1:0] got[$];
    int first_ov = -1;
    int peak = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      in_valid = (c < 3);
      d = (c < 3) ? words[c] : WIDTH'($urandom);
      #1;
      n_tests += 3;
      if (in_ready !== m_in_ready()) begin n_fail++; $display("FAIL latency_in_ready c=%0d got %b want %b", c, in_ready, m_in_ready()); end
      if (out_valid !== m_out_valid()) begin n_fail++; $display("FAIL latency_out_valid c=%0d got %b want %b", c, out_valid, m_out_valid()); end
      if (count !== CNT_W'(m_count())) begin n_fail++; $display("FAIL latency_count c=%0d got %0d want %0d", c, count, m_count()); end
      if (m_out_valid()) begin
        n_tests++;
        if (q !== exp_q[0]) begin n_fail++; $display("FAIL latency_q c=%0d got %h want %h", c, q, exp_q[0]); end
      end
      if (out_valid === 1'b1 && first_ov < 0) first_ov = c;
      if (out_valid === 1'b1) got.push_back(q);
      if (int'(count) > peak) peak = int'(count);
      tick();
    end
    in_valid = 1'b0;
    // Accepted on edge 0, visible after edge DEPTH-1, i.e. in cycle DEPTH.
    n_tests += 3;
    if (first_ov != DEPTH) begin n_fail++; $display("FAIL latency_first_valid got cycle %0d want %0d", first_ov, DEPTH); end
    if (got.size() != 3 || got[0] !== 8'h11 || got[1] !== 8'h22 || got[2] !== 8'h33) begin
      n_fail++; $display("FAIL latency_order got %p want 11 22 33", got);
    end
    if (peak != m_peak(3)) begin n_fail++; $display("FAIL latency_peak_count got %0d want %0d", peak, m_peak(3)); end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] got[$];
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      d = WIDTH'(c + 1);
      #1;
      n_tests += 3;
      if (in_ready !== m_in_ready()) begin n_fail++; $display("FAIL bp_in_ready c=%0d got %b want %b", c, in_ready, m_in_ready()); end
      if (out_valid !== m_out_valid()) begin n_fail++; $display("FAIL bp_out_valid c=%0d got %b want %b", c, out_valid, m_out_valid()); end
      if (count !== CNT_W'(m_count())) begin n_fail++; $display("FAIL bp_count c=%0d got %0d want %0d", c, count, m_count()); end
      tick();
    end
    #1;
    n_tests += 2;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_in_ready got %b want 0", in_ready); end
    if (count !== CNT_W'(m_peak(4))) begin n_fail++; $display("FAIL bp_full_count got %0d want %0d", count, m_peak(4)); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      #1;
      n_tests += 2;
      if (out_valid !== m_out_valid()) begin n_fail++; $display("FAIL bp_drain_out_valid c=%0d got %b want %b", c, out_valid, m_out_valid()); end
      if (count !== CNT_W'(m_count())) begin n_fail++; $display("FAIL bp_drain_count c=%0d got %0d want %0d", c, count, m_count()); end
      if (out_valid === 1'b1) got.push_back(q);
      tick();
    end
    n_tests++;
    if (got.size() != 4 || got[0] !== 8'h01 || got[1] !== 8'h02 || got[2] !== 8'h03 || got[3] !== 8'h04) begin
      n_fail++; $display("FAIL bp_drain_order got %p want 01 02 03 04", got);
    end
  endtask

  task automatic test_bubble();
    bit pattern[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    out_ready = 1'b0;
    for (int c = 0; c < 9; c++) begin
      in_valid = (c < 4) ? pattern[c] : 1'b0;
      d = (c == 0) ? 8'hA5 : (c == 3) ? 8'h5B : WIDTH'($urandom);
      #1;
      n_tests += 3;
      if (in_ready !== m_in_ready()) begin n_fail++; $display("FAIL bubble_in_ready c=%0d got %b want %b", c, in_ready, m_in_ready()); end
      if (out_valid !== m_out_valid()) begin n_fail++; $display("FAIL bubble_out_valid c=%0d got %b want %b", c, out_valid, m_out_valid()); end
      if (count !== CNT_W'(m_count())) begin n_fail++; $display("FAIL bubble_count c=%0d got %0d want %0d", c, count, m_count()); end
      tick();
    end
    in_valid = 1'b0;
    #1;
    n_tests += 3;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bubble_settled_valid got %b want 1", out_valid); end
    if (q !== 8'hA5) begin n_fail++; $display("FAIL bubble_settled_q got %h want a5", q); end
    if (count !== CNT_W'(m_peak(2))) begin n_fail++; $display("FAIL bubble_settled_count got %0d want %0d", count, m_peak(2)); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    // B must already sit directly behind A, so it is on q one edge later.
    n_tests += 2;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bubble_adjacent_valid got %b want 1", out_valid); end
    if (q !== 8'h5B) begin n_fail++; $display("FAIL bubble_adjacent_q got %h want 5b", q); end
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) tick();
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] sent[$];
    logic [WIDTH-1:0] got[$];
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1;
      d = WIDTH'($urandom);
      sent.push_back(d);
      tick();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      d = WIDTH'($urandom);
      sent.push_back(d);
      #1;
      n_tests += 3;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready c=%0d got %b want 1", c, in_ready); end
      if (count !== CNT_W'(m_peak(4))) begin n_fail++; $display("FAIL b2b_count c=%0d got %0d want %0d", c, count, m_peak(4)); end
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_out_valid c=%0d got %b want 1", c, out_valid); end
      if (out_valid === 1'b1) got.push_back(q);
      tick();
    end
    in_valid = 1'b0;
    n_tests++;
    if (got.size() != 10 || got != sent[0:9]) begin n_fail++; $display("FAIL b2b_order got %p want %p", got, sent[0:9]); end
    for (int c = 0; c < 6; c++) tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      d = WIDTH'(8'h30 + c);
      tick();
    end
    flush = 1'b1;
    in_valid = 1'b1;
    d = 8'hEE;
    #1;
    n_tests += 2;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
    if (count !== CNT_W'(m_peak(3))) begin n_fail++; $display("FAIL flush_pre_count got %0d want %0d", count, m_peak(3)); end
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      n_tests += 2;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid c=%0d got %b want 0", c, out_valid); end
      if (count !== '0) begin n_fail++; $display("FAIL flush_count c=%0d got %0d want 0", c, count); end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      d         = WIDTH'($urandom);
      #1;
      n_tests += 3;
      if (in_ready !== m_in_ready()) begin n_fail++; $display("FAIL rand_in_ready c=%0d got %b want %b", c, in_ready, m_in_ready()); end
      if (out_valid !== m_out_valid()) begin n_fail++; $display("FAIL rand_out_valid c=%0d got %b want %b", c, out_valid, m_out_valid()); end
      if (count !== CNT_W'(m_count())) begin n_fail++; $display("FAIL rand_count c=%0d got %0d want %0d", c, count, m_count()); end
      if (m_out_valid()) begin
        n_tests++;
        if (q !== exp_q[0]) begin n_fail++; $display("FAIL rand_q c=%0d got %h want %h", c, q, exp_q[0]); end
      end
      tick();
    end
    flush = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_reset_midstream();
    logic [WIDTH-1:0] got[$];
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      d = WIDTH'(8'hC0 + c);
      tick();
    end
    for (int c = 0; c < 3; c++) tick();
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    pos_q.delete();
    n_tests += 3;
    if (q !== '0) begin n_fail++; $display("FAIL midreset_q got %h want 00", q); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_out_valid got %b want 0", out_valid); end
    if (count !== '0) begin n_fail++; $display("FAIL midreset_count got %0d want 0", count); end
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_valid = (c < 2);
      d = (c == 0) ? 8'h77 : 8'h88;
      #1;
      n_tests += 2;
      if (in_ready !== m_in_ready()) begin n_fail++; $display("FAIL midreset_resume_ready c=%0d got %b want %b", c, in_ready, m_in_ready()); end
      if (out_valid !== m_out_valid()) begin n_fail++; $display("FAIL midreset_resume_valid c=%0d got %b want %b", c, out_valid, m_out_valid()); end
      if (out_valid === 1'b1) got.push_back(q);
      tick();
    end
    in_valid = 1'b0;
    n_tests++;
    if (got.size() != 2 || got[0] !== 8'h77 || got[1] !== 8'h88) begin
      n_fail++; $display("FAIL midreset_resume_order got %p want 77 88", got);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_latency();
    test_backpressure();
    test_bubble();
    test_back_to_back();
    test_flush();
    test_random();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
